// File: rtl/uart_tx_fifo_rd_if.sv
// FIFO read-port handshake between a synchronous FIFO (master) and the UART transmitter (slave).
interface uart_tx_fifo_rd_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rack;

    modport master (output rready, output rdata, input rack);
    modport slave  (input rready, input rdata, output rack);
endinterface

// File: rtl/uart_tx_fifo_rd.sv
// Serial transmitter draining a FIFO read port: start, DATA_WIDTH bits LSB first, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_rd #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_fifo_rd_if.slave  rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  cyc_last;
    logic                  take;
    logic                  done;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign cyc_last = (cyc_q == CYC_LAST);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        take    = 1'b0;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
        end

        case (state_q)
            S_IDLE: take = rd.rready;
            S_START: begin
                if (cyc_last) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cyc_last) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (cyc_last) begin
                    if (bit_q == STOP_LAST) begin
                        done    = 1'b1;
                        take    = rd.rready;
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accepting a word restarts the frame regardless of where we came from.
        if (take) begin
            state_d = S_START;
            shift_d = rd.rdata;
            cyc_d   = '0;
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^rd.rdata;
`endif
        end

        // tx and busy are registered from the next state so the line changes one edge after rack.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rd.rack    = rst & take;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done;
endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Bench for uart_tx_fifo_rd: frame-level model compared every cycle plus directed literal checks.
module tb_uart_tx_fifo_rd;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam int EXP_LEN_A  = 44;
    localparam int EXP_LEN_B  = 48;
    localparam logic [15:0] EXP_A5 = 16'h054A;
    localparam logic [15:0] EXP_FF = 16'h05FE;
    localparam logic [15:0] EXP_81 = 16'h0502;
    localparam logic [15:0] EXP_07 = 16'h0E0E;
`else
    localparam int P = 0;
    localparam int EXP_LEN_A  = 40;
    localparam int EXP_LEN_B  = 44;
    localparam logic [15:0] EXP_A5 = 16'h034A;
    localparam logic [15:0] EXP_FF = 16'h03FE;
    localparam logic [15:0] EXP_81 = 16'h0302;
    localparam logic [15:0] EXP_07 = 16'h060E;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    uart_tx_fifo_rd_if #(.DATA_WIDTH(8)) if_a ();
    uart_tx_fifo_rd_if #(.DATA_WIDTH(8)) if_b ();
    logic tx_a, busy_a, fd_a, tx_b, busy_b, fd_b;

    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rd(if_a.slave), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));
    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rd(if_b.slave), .tx(tx_b), .busy(busy_b), .frame_done(fd_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of bits, each held CPB cycles.
    typedef struct {
        bit          active;
        logic [15:0] bits;
        int          nbits;
        int          idx;
    } mdl_t;
    mdl_t ma = '{0, 16'hFFFF, 0, 0};
    mdl_t mb = '{0, 16'hFFFF, 0, 0};

    function automatic logic [15:0] frame_bits(input logic [7:0] w);
        logic [15:0] f;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = w[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^w;
`endif
        return f;
    endfunction

    task automatic eval(input string tag, inout mdl_t m, input int stop, input logic rr,
                        input logic [7:0] rdv, input logic rk, input logic txv,
                        input logic bz, input logic fd);
        bit last, erack;
        if (!rst) m.active = 0;
        last  = m.active && (m.idx == m.nbits * CPB - 1);
        erack = rst && rr && (!m.active || last);
        check({tag, " rack"}, {31'd0, rk}, {31'd0, erack});
        check({tag, " tx"}, {31'd0, txv}, {31'd0, m.active ? m.bits[m.idx / CPB] : 1'b1});
        check({tag, " busy"}, {31'd0, bz}, {31'd0, m.active});
        check({tag, " frame_done"}, {31'd0, fd}, {31'd0, last});
        if (erack) begin
            m.active = 1;
            m.bits   = frame_bits(rdv);
            m.nbits  = 1 + 8 + P + stop;
            m.idx    = 0;
        end else if (last) begin
            m.active = 0;
        end else if (m.active) begin
            m.idx++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        eval("a", ma, 1, if_a.rready, if_a.rdata, if_a.rack, tx_a, busy_a, fd_a);
        eval("b", mb, 2, if_b.rready, if_b.rdata, if_b.rack, tx_b, busy_b, fd_b);
    end

    // FIFO emulation: head word presented while non-empty, garbage on rdata otherwise.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    initial begin
        bit pa, pb;
        if_a.rready = 1'b0; if_a.rdata = 8'h00;
        if_b.rready = 1'b0; if_b.rdata = 8'h00;
        forever begin
            @(negedge clk);
            pa = if_a.rack;
            pb = if_b.rack;
            @(posedge clk);
            #1;
            if (pa && qa.size() > 0) void'(qa.pop_front());
            if (pb && qb.size() > 0) void'(qb.pop_front());
            if_a.rready = (qa.size() != 0);
            if_a.rdata  = (qa.size() != 0) ? qa[0] : 8'($urandom);
            if_b.rready = (qb.size() != 0);
            if_b.rdata  = (qb.size() != 0) ? qb[0] : 8'($urandom);
        end
    end

    task automatic wait_rack(input int inst, input string name);
        bit seen;
        seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if ((inst != 0) ? if_b.rack : if_a.rack) begin
                seen = 1;
                break;
            end
        end
        check({name, " rack seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Called at the rack negedge; samples each bit mid-way and times frame_done.
    task automatic measure_frame(input int inst, output logic [15:0] bits, output int fd_at);
        logic txv, fdv;
        bits  = '0;
        fd_at = 0;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            txv = (inst != 0) ? tx_b : tx_a;
            fdv = (inst != 0) ? fd_b : fd_a;
            if (t >= 2 && (t - 2) % CPB == 0 && (t - 2) / CPB < 16) bits[(t - 2) / CPB] = txv;
            if (fdv) begin
                fd_at = t;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        int fd_at, gap, low_cnt, rk_cnt, txl_cnt, bz_cnt;

        // Reset held with a word waiting.
        rst = 1'b0;
        qa.push_back(8'hA5);
        repeat (5) @(negedge clk);
        check("reset tx", {31'd0, tx_a}, 32'd1);
        check("reset busy", {31'd0, busy_a}, 32'd0);
        check("reset rack", {31'd0, if_a.rack}, 32'd0);
        check("reset frame_done", {31'd0, fd_a}, 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Single word A5.
        wait_rack(0, "a5");
        measure_frame(0, bits, fd_at);
        check("a5 bits", {16'd0, bits}, {16'd0, EXP_A5});
        check("a5 frame_done offset", fd_at, EXP_LEN_A);

        // Back-to-back 00 then FF.
        @(negedge clk);
        qa.push_back(8'h00);
        qa.push_back(8'hFF);
        wait_rack(0, "b2b first");
        gap = 0; low_cnt = 0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (!busy_a) low_cnt++;
            if (if_a.rack) begin
                gap = t;
                break;
            end
        end
        check("b2b rack spacing", gap, EXP_LEN_A);
        check("b2b busy gaps", low_cnt, 0);
        measure_frame(0, bits, fd_at);
        check("ff bits", {16'd0, bits}, {16'd0, EXP_FF});

        // Empty FIFO window.
        rk_cnt = 0; txl_cnt = 0; bz_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (if_a.rack) rk_cnt++;
            if (!tx_a) txl_cnt++;
            if (busy_a) bz_cnt++;
        end
        check("empty rack count", rk_cnt, 0);
        check("empty tx low count", txl_cnt, 0);
        check("empty busy count", bz_cnt, 0);

        // Reset during data bit 3 of 3C, then 81 after release.
        qa.push_back(8'h3C);
        wait_rack(0, "3c");
        repeat (18) @(negedge clk);
        check("3c in flight busy", {31'd0, busy_a}, 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("midreset tx", {31'd0, tx_a}, 32'd1);
        check("midreset busy", {31'd0, busy_a}, 32'd0);
        qa.push_back(8'h81);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        wait_rack(0, "81");
        measure_frame(0, bits, fd_at);
        check("81 bits", {16'd0, bits}, {16'd0, EXP_81});
        check("81 frame_done offset", fd_at, EXP_LEN_A);

        // Two stop bits on the second instance.
        @(negedge clk);
        qb.push_back(8'h07);
        wait_rack(1, "07");
        measure_frame(1, bits, fd_at);
        check("07 bits", {16'd0, bits}, {16'd0, EXP_07});
        check("07 frame_done offset", fd_at, EXP_LEN_B);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
